// File: rtl/elf_ram_upload.sv
// CosmacELF RAM upload server: answers HPS ioctl_rd byte requests with registered
// RAM reads and holds the CPU off RAM for the whole upload.
module elf_ram_upload #(
  parameter int         ADDR_W = 12,
  parameter int         SIZE   = 4096,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] INDEX  = 8'd2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_trig,
  output logic              ioctl_upload_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              cpu_hold,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE, FETCH} state_t;

  state_t     state, state_nxt;
  logic       trig_q;
  logic [1:0] lat_cnt;
  logic       oor;

  logic trig_rise, upload_match, in_range;
  logic rd_accept, capture, end_xfer;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    trig_rise    = save_trig & ~trig_q;
    upload_match = ioctl_upload && (ioctl_index == INDEX);
    // Full 25-bit compare: high address bits must never alias into RAM.
    in_range     = ioctl_addr < 25'(SIZE);
    state_nxt    = state;
    rd_accept    = 1'b0;
    capture      = 1'b0;
    end_xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise)         state_nxt = REQ;
        else if (upload_match) state_nxt = ACTIVE;
      end
      REQ: begin
        if (upload_match) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!ioctl_upload) begin
          end_xfer  = 1'b1;
          state_nxt = IDLE;
        end else if (ioctl_rd) begin
          rd_accept = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (!ioctl_upload) begin
          end_xfer  = 1'b1;
          state_nxt = IDLE;
        end else if (lat_cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state            <= IDLE;
      trig_q           <= 1'b0;
      lat_cnt          <= 2'd0;
      oor              <= 1'b0;
      ioctl_upload_req <= 1'b0;
      ioctl_din        <= 8'h00;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      cpu_hold         <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_nxt;
      trig_q           <= save_trig;
      // Outputs follow the current state one cycle later; req drops on the grant edge.
      ioctl_upload_req <= (state == REQ) && (state_nxt == REQ);
      cpu_hold         <= (state != IDLE);
      done             <= end_xfer;
      ram_rd           <= rd_accept && in_range;
      if (rd_accept) begin
        oor     <= ~in_range;
        lat_cnt <= 2'(RD_LAT);
        if (in_range) ram_addr <= ioctl_addr[ADDR_W-1:0];
      end else if (state == FETCH && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (capture) ioctl_din <= oor ? 8'hFF : ram_q;
    end
  end

endmodule
